// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate L1 data cache with 16-byte lines
// and a busy-wait block port to main memory.
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   READ,
    input  logic [2:0]   WRITE,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSY_WAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);
    localparam int TAG_BITS = 28 - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, EVICT, FETCH, UPDATE} state_t;

    state_t state, state_next;
    logic [127:0] data_arr [LINES];
    logic [TAG_BITS-1:0] tag_arr [LINES];
    logic [LINES-1:0] valid, dirty;
    logic [127:0] fetch_buf;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic [127:0] line, merged;
    logic [31:0] word, store_word, load_word;
    logic [7:0] byte_v;
    logic [15:0] half_v;
    logic wr_req, rd_req, req, hit, served;

    assign idx = ADDRESS[4 +: INDEX_BITS];
    assign tag = ADDRESS[31 -: TAG_BITS];
    assign line = data_arr[idx];
    assign word = line[{ADDRESS[3:2], 5'b0} +: 32];
    assign byte_v = word[{ADDRESS[1:0], 3'b0} +: 8];
    assign half_v = word[{ADDRESS[1], 4'b0} +: 16];
    // A simultaneous read and write is served as the write alone
    assign wr_req = WRITE[2];
    assign rd_req = READ[3] & ~wr_req;
    assign req = rd_req | wr_req;
    assign hit = valid[idx] && (tag_arr[idx] == tag);
    assign served = !RESET && (state == IDLE) && hit;
    assign BUSY_WAIT = !RESET && req && !served;
    assign READDATA = (served && rd_req) ? load_word : '0;

    always_comb begin
        load_word = (READ[2:0] == 3'b000) ? {{24{byte_v[7]}}, byte_v} :
                    (READ[2:0] == 3'b001) ? {{16{half_v[15]}}, half_v} :
                    (READ[2:0] == 3'b100) ? {24'b0, byte_v} :
                    (READ[2:0] == 3'b101) ? {16'b0, half_v} : word;
    end

    always_comb begin
        store_word = word;
        if (WRITE[1:0] == 2'b00)
            store_word[{ADDRESS[1:0], 3'b0} +: 8] = WRITEDATA[7:0];
        else if (WRITE[1:0] == 2'b01)
            store_word[{ADDRESS[1], 4'b0} +: 16] = WRITEDATA[15:0];
        else
            store_word = WRITEDATA;
        merged = line;
        merged[{ADDRESS[3:2], 5'b0} +: 32] = store_word;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req && !hit) state_next = dirty[idx] ? EVICT : FETCH;
            EVICT:   if (!MEM_BUSYWAIT) state_next = FETCH;
            FETCH:   if (!MEM_BUSYWAIT) state_next = UPDATE;
            default: state_next = IDLE;
        endcase
        MEM_READ = (state == FETCH);
        MEM_WRITE = (state == EVICT);
        MEM_ADDRESS = (state == EVICT) ? {tag_arr[idx], idx} : ADDRESS[31:4];
        MEM_WRITEDATA = line;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_next;
            if (state == UPDATE) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end else if (served && wr_req) begin
                dirty[idx] <= 1'b1;
            end
        end
    end

    // Arrays carry no reset; only the valid bits decide whether their contents count
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state == FETCH && !MEM_BUSYWAIT) fetch_buf <= MEM_READDATA;
            if (state == UPDATE) begin
                data_arr[idx] <= fetch_buf;
                tag_arr[idx] <= tag;
            end else if (served && wr_req) begin
                data_arr[idx] <= merged;
            end
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: scoreboard bench for data_cache against a small busy-wait block memory model.
module tb_data_cache;
    localparam int LAT = 2;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [3:0]   READ;
    logic [2:0]   WRITE;
    logic [31:0]  ADDRESS;
    logic [31:0]  WRITEDATA;
    logic [31:0]  READDATA;
    logic         BUSY_WAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    data_cache dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSY_WAIT(BUSY_WAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory holds busywait for LAT cycles per transaction, then completes on the next edge
    logic [127:0] mem [256];
    logic [3:0] cnt = '0;
    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt < 4'(LAT));
    assign MEM_READDATA = mem[MEM_ADDRESS[7:0]];
    always @(posedge CLK) begin
        cnt <= MEM_BUSYWAIT ? cnt + 4'd1 : 4'd0;
        if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS[7:0]] <= MEM_WRITEDATA;
    end

    int n_wr = 0;
    logic [27:0] ev_addr = '0, fe_addr = '0;
    logic [127:0] ev_data = '0;
    always @(negedge CLK) begin
        if (MEM_WRITE) begin
            n_wr++;
            ev_addr = MEM_ADDRESS;
            ev_data = MEM_WRITEDATA;
        end
        if (MEM_READ) fe_addr = MEM_ADDRESS;
    end

    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    string name_q[$];

    task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                          input logic [31:0] wd, output int stalls);
        @(posedge CLK);
        #1;
        READ = rd;
        WRITE = wr;
        ADDRESS = addr;
        WRITEDATA = wd;
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (!BUSY_WAIT) break;
            stalls++;
        end
        if (BUSY_WAIT) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout addr=%h: BUSY_WAIT still 1 after 64 cycles, required 0", addr);
        end
    endtask

    task automatic go_idle();
        @(posedge CLK);
        #1;
        READ = 4'b0;
        WRITE = 3'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        READ = 4'b0;
        WRITE = 3'b0;
        ADDRESS = '0;
        WRITEDATA = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_tests++;
        if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0 || BUSY_WAIT !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: rd=%b wr=%b busy=%b, required 0 0 0", MEM_READ, MEM_WRITE, BUSY_WAIT);
        end
        READ = 4'b1010;
        ADDRESS = 32'h40;
        @(negedge CLK);
        n_tests++;
        if (BUSY_WAIT !== 1'b0 || READDATA !== 32'h0 || MEM_READ !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b data=%h mrd=%b, required 0 0 0", BUSY_WAIT, READDATA, MEM_READ);
        end
        READ = 4'b0;
        RESET = 1'b0;
    endtask

    task automatic test_fetch();
        int stalls;
        logic [31:0] exp;
        exp_q.push_back(32'hDEADBEEF);
        name_q.push_back("lw_40_refill");
        @(posedge CLK);
        #1;
        READ = 4'b1010;
        WRITE = 3'b0;
        ADDRESS = 32'h40;
        @(negedge CLK);
        n_tests++;
        if (BUSY_WAIT !== 1'b1 || MEM_READ !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_busy: busy=%b mrd=%b, required 1 0", BUSY_WAIT, MEM_READ);
        end
        @(negedge CLK);
        n_tests++;
        if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 28'h4 || MEM_WRITE !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_req: mrd=%b addr=%h mwr=%b, required 1 0000004 0", MEM_READ, MEM_ADDRESS, MEM_WRITE);
        end
        stalls = 2;
        for (int i = 0; i < 64 && BUSY_WAIT; i++) begin
            @(negedge CLK);
            if (BUSY_WAIT) stalls++;
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (READDATA !== exp || BUSY_WAIT !== 1'b0 || stalls != LAT + 3) begin
            n_fail++;
            $display("FAIL %s: data=%h busy=%b stalls=%0d, required %h 0 %0d", name_q.pop_front(), READDATA, BUSY_WAIT, stalls, exp, LAT + 3);
        end else void'(name_q.pop_front());
    endtask

    task automatic test_extend();
        logic [31:0] a [6] = '{32'h60, 32'h63, 32'h63, 32'h62, 32'h62, 32'h63};
        logic [2:0]  f [6] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
        logic [31:0] e [6] = '{32'h80FF0000, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'hFFFF80FF};
        int s [6] = '{LAT + 3, 0, 0, 0, 0, 0};
        int stalls;
        logic [31:0] exp;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(e[i]);
            name_q.push_back($sformatf("load_ext_%0d", i));
            access({1'b1, f[i]}, 3'b0, a[i], 32'h0, stalls);
            exp = exp_q.pop_front();
            n_tests++;
            if (READDATA !== exp || stalls != s[i]) begin
                n_fail++;
                $display("FAIL %s: data=%h stalls=%0d, required %h %0d", name_q.pop_front(), READDATA, stalls, exp, s[i]);
            end else void'(name_q.pop_front());
        end
    endtask

    task automatic test_store_hit();
        int stalls;
        logic [31:0] exp;
        access(4'b0, 3'b101, 32'h42, 32'h00001234, stalls);
        n_tests++;
        if (stalls != 0) begin
            n_fail++;
            $display("FAIL sh_hit_stall: stalls=%0d, required 0", stalls);
        end
        exp_q.push_back(32'h1234BEEF);
        name_q.push_back("lw_after_sh");
        access(4'b1010, 3'b0, 32'h40, 32'h0, stalls);
        exp = exp_q.pop_front();
        n_tests++;
        if (READDATA !== exp || stalls != 0 || n_wr != 0) begin
            n_fail++;
            $display("FAIL %s: data=%h stalls=%0d memwrites=%0d, required %h 0 0", name_q.pop_front(), READDATA, stalls, n_wr, exp);
        end else void'(name_q.pop_front());
    endtask

    task automatic test_evict();
        int stalls;
        logic [31:0] exp;
        exp_q.push_back(32'hCAFE0000);
        name_q.push_back("lw_c0_evict");
        access(4'b1010, 3'b0, 32'hC0, 32'h0, stalls);
        exp = exp_q.pop_front();
        n_tests++;
        if (READDATA !== exp) begin
            n_fail++;
            $display("FAIL %s: data=%h, required %h", name_q.pop_front(), READDATA, exp);
        end else void'(name_q.pop_front());
        n_tests++;
        if (n_wr == 0 || ev_addr !== 28'h4 || ev_data[31:0] !== 32'h1234BEEF) begin
            n_fail++;
            $display("FAIL evict_block: writes=%0d addr=%h w0=%h, required >0 0000004 1234beef", n_wr, ev_addr, ev_data[31:0]);
        end
        n_tests++;
        if (fe_addr !== 28'hC || stalls < 2 * LAT + 4) begin
            n_fail++;
            $display("FAIL evict_fetch: addr=%h stalls=%0d, required 000000c >=%0d", fe_addr, stalls, 2 * LAT + 4);
        end
    endtask

    task automatic test_reset_abort();
        int stalls;
        logic [31:0] exp;
        @(posedge CLK);
        #1;
        READ = 4'b1010;
        WRITE = 3'b0;
        ADDRESS = 32'h80;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (MEM_READ) break;
        end
        n_tests++;
        if (MEM_READ !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_fetch_start: mrd=%b, required 1", MEM_READ);
        end
        RESET = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (MEM_READ !== 1'b0 || BUSY_WAIT !== 1'b0 || READDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_reset: mrd=%b busy=%b data=%h, required 0 0 0", MEM_READ, BUSY_WAIT, READDATA);
        end
        RESET = 1'b0;
        READ = 4'b0;
        exp_q.push_back(32'h1234BEEF);
        name_q.push_back("lw_40_after_reset");
        access(4'b1010, 3'b0, 32'h40, 32'h0, stalls);
        exp = exp_q.pop_front();
        n_tests++;
        if (READDATA !== exp || stalls != LAT + 3) begin
            n_fail++;
            $display("FAIL %s: data=%h stalls=%0d, required %h %0d", name_q.pop_front(), READDATA, stalls, exp, LAT + 3);
        end else void'(name_q.pop_front());
    endtask

    task automatic test_read_write();
        int stalls;
        logic [31:0] exp;
        access(4'b1010, 3'b110, 32'h50, 32'hA5A5A5A5, stalls);
        n_tests++;
        if (READDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL rw_read_ignored: data=%h, required 00000000", READDATA);
        end
        exp_q.push_back(32'hA5A5A5A5);
        name_q.push_back("lw_50_after_rw");
        access(4'b1010, 3'b0, 32'h50, 32'h0, stalls);
        exp = exp_q.pop_front();
        n_tests++;
        if (READDATA !== exp || stalls != 0) begin
            n_fail++;
            $display("FAIL %s: data=%h stalls=%0d, required %h 0", name_q.pop_front(), READDATA, stalls, exp);
        end else void'(name_q.pop_front());
    endtask

    task automatic test_back_to_back();
        logic [3:0]  r [6] = '{4'b0, 4'b0, 4'b1010, 4'b1010, 4'b1000, 4'b1101};
        logic [2:0]  w [6] = '{3'b100, 3'b110, 3'b0, 3'b0, 3'b0, 3'b0};
        logic [31:0] a [6] = '{32'h61, 32'h6C, 32'h6C, 32'h60, 32'h61, 32'h6E};
        logic [31:0] d [6] = '{32'h000000EE, 32'h11223344, 0, 0, 0, 0};
        logic [31:0] e [6] = '{0, 0, 32'h11223344, 32'h80FFEE00, 32'hFFFFFFEE, 32'h00001122};
        int stalls;
        logic [31:0] exp;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(e[i]);
            name_q.push_back($sformatf("b2b_%0d", i));
            access(r[i], w[i], a[i], d[i], stalls);
            exp = exp_q.pop_front();
            n_tests++;
            if (READDATA !== exp || (i > 0 && stalls != 0)) begin
                n_fail++;
                $display("FAIL %s: data=%h stalls=%0d, required %h 0", name_q.pop_front(), READDATA, stalls, exp);
            end else void'(name_q.pop_front());
        end
        go_idle();
        @(negedge CLK);
        n_tests++;
        if (READDATA !== 32'h0 || BUSY_WAIT !== 1'b0) begin
            n_fail++;
            $display("FAIL no_request: data=%h busy=%b, required 00000000 0", READDATA, BUSY_WAIT);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {4{8'(i), 24'h0}};
        mem[4] = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        mem[6] = {32'h66666666, 32'h55555555, 32'h44444444, 32'h80FF0000};
        mem[12] = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA, 32'hCAFE0000};
        test_reset();
        test_fetch();
        test_extend();
        test_store_hit();
        test_evict();
        test_reset_abort();
        test_read_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end
endmodule
